// File: rtl/bird_motion_if.sv
// Bird controller bus.
// Groups the player/game-logic requests (start, kill, jump, fall) and the
// registered bird state that feeds the sprite renderer and collision logic.
//   master : game side, drives requests and observes bird state
//   slave  : bird_motion, consumes requests and drives bird state
interface bird_motion_if;
    logic              start;
    logic              kill;
    logic              jump;
    logic              fall;
    logic [9:0]        x;
    logic [8:0]        y;
    logic signed [7:0] vy;
    logic [2:0]        state;
    logic [1:0]        animation_state;
    logic [2:0]        lives;
    logic              visible;

    modport master (
        output start, kill, jump, fall,
        input  x, y, vy, state, animation_state, lives, visible
    );

    modport slave (
        input  start, kill, jump, fall,
        output x, y, vy, state, animation_state, lives, visible
    );
endinterface

// File: rtl/bird_motion.sv
// Bird controller for the danmaku-bird game, clocked by the 100 Hz game tick.
// Owns bird position, signed vertical velocity, lives with post-hit
// invulnerability, the death-fall sequence and the wing animation frame.
// Ports:
//   clk_100Hz : game tick clock
//   rst_n     : asynchronous active-low reset
//   bus       : bird_motion_if slave (start/kill/jump/fall in; x, y, vy,
//               state, animation_state, lives, visible out, all registered)
module bird_motion #(
    parameter int unsigned X_POS        = 160,
    parameter int unsigned Y_INIT       = 200,
    parameter int unsigned Y_MIN        = 0,
    parameter int unsigned Y_MAX        = 440,
    parameter int unsigned GRAVITY      = 1,
    parameter int unsigned JUMP_VEL     = 6,
    parameter int unsigned VMAX         = 10,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned INVULN_TICKS = 100,
    parameter int unsigned ANIM_DIV     = 8
) (
    input logic          clk_100Hz,
    input logic          rst_n,
    bird_motion_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFly   = 3'd1,
        StHit   = 3'd2,
        StDying = 3'd3,
        StDead  = 3'd4
    } state_e;

    localparam logic signed [9:0]  VMAX_S   = 10'(VMAX);
    localparam logic signed [9:0]  GRAV_S   = 10'(GRAVITY);
    localparam logic signed [7:0]  VY_JUMP  = 8'(-int'(JUMP_VEL));
    localparam logic signed [7:0]  VY_FALL  = 8'(VMAX);
    localparam logic signed [10:0] YMIN_S   = 11'(Y_MIN);
    localparam logic signed [10:0] YMAX_S   = 11'(Y_MAX);
    localparam logic [7:0]         DIV_LAST = 8'(ANIM_DIV - 1);
    localparam logic [15:0]        INV_LOAD = 16'(INVULN_TICKS);

    state_e            state_q, state_d;
    logic [8:0]        y_q, y_d;
    logic signed [7:0] vy_q, vy_d;
    logic [2:0]        lives_q, lives_d;
    logic              visible_q, visible_d;
    logic [1:0]        anim_q, anim_d;
    logic [1:0]        frame_q, frame_d;
    logic [7:0]        div_q, div_d;
    logic [15:0]       inv_q, inv_d;
    logic [2:0]        blink_q, blink_d;
    logic              jump_q, fall_q;

    logic              jump_edge, fall_edge;
    logic signed [9:0] vy_ext, vy_sum;
    logic signed [7:0] vy_grav, vy_flap, vy_mot, vy_out;
    logic signed [10:0] y_sum;
    logic              hit_ceil, hit_floor;
    logic [8:0]        y_mot;

    assign jump_edge = bus.jump & ~jump_q;
    assign fall_edge = bus.fall & ~fall_q;

    // Velocity candidates: gravity with terminal-speed saturation, and the
    // player-controlled variant where a jump edge beats a fall edge.
    always_comb begin
        vy_ext  = {{2{vy_q[7]}}, vy_q};
        vy_sum  = vy_ext + GRAV_S;
        vy_grav = (vy_sum > VMAX_S) ? VMAX_S[7:0] : vy_sum[7:0];
        if (jump_edge) begin
            vy_flap = VY_JUMP;
        end else if (fall_edge) begin
            vy_flap = VY_FALL;
        end else begin
            vy_flap = vy_grav;
        end
        // The death fall ignores the player.
        vy_mot = (state_q == StDying) ? vy_grav : vy_flap;
    end

    // Position update in signed 11 bits so an upward move past the ceiling
    // shows up as a non-positive sum instead of wrapping.
    always_comb begin
        y_sum     = $signed({2'b00, y_q}) + $signed({{3{vy_mot[7]}}, vy_mot});
        hit_ceil  = (y_sum <= YMIN_S);
        hit_floor = !hit_ceil && (y_sum >= YMAX_S);
        if (hit_ceil) begin
            y_mot  = 9'(Y_MIN);
            vy_out = '0;
        end else if (hit_floor) begin
            y_mot  = 9'(Y_MAX);
            vy_out = vy_mot;
        end else begin
            y_mot  = y_sum[8:0];
            vy_out = vy_mot;
        end
    end

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        vy_d      = vy_q;
        lives_d   = lives_q;
        visible_d = visible_q;
        inv_d     = inv_q;
        blink_d   = blink_q;

        // Wing animation; a jump edge restarts the wing beat.
        if (jump_edge) begin
            div_d   = '0;
            frame_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d   = '0;
            frame_d = (frame_q == 2'd2) ? 2'd0 : frame_q + 2'd1;
        end else begin
            div_d   = div_q + 8'd1;
            frame_d = frame_q;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StFly;
                    vy_d    = '0;
                    div_d   = '0;
                    frame_d = '0;
                end
            end
            StFly: begin
                y_d  = y_mot;
                vy_d = vy_out;
                // Floor contact and a bullet in the same tick cost one life.
                if (bus.kill || hit_floor) begin
                    if (lives_q > 3'd1) begin
                        lives_d = lives_q - 3'd1;
                        state_d = StHit;
                        inv_d   = INV_LOAD;
                        blink_d = '0;
                    end else begin
                        lives_d = '0;
                        state_d = StDying;
                        vy_d    = '0;
                    end
                end
            end
            StHit: begin
                y_d     = y_mot;
                vy_d    = vy_out;
                inv_d   = inv_q - 16'd1;
                blink_d = blink_q + 3'd1;
                if (blink_q == 3'd7) begin
                    visible_d = ~visible_q;
                end
                if (inv_q == 16'd1) begin
                    state_d   = StFly;
                    visible_d = 1'b1;
                end
            end
            StDying: begin
                div_d   = div_q;
                frame_d = frame_q;
                y_d     = y_mot;
                vy_d    = vy_out;
                if (hit_floor) begin
                    state_d = StDead;
                    vy_d    = '0;
                end
            end
            StDead: begin
                div_d   = div_q;
                frame_d = frame_q;
                if (bus.start) begin
                    state_d   = StFly;
                    y_d       = 9'(Y_INIT);
                    vy_d      = '0;
                    lives_d   = 3'(LIVES);
                    visible_d = 1'b1;
                    div_d     = '0;
                    frame_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        anim_d = ((state_d == StDying) || (state_d == StDead)) ? 2'd3 : frame_d;
    end

    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            y_q       <= 9'(Y_INIT);
            vy_q      <= '0;
            lives_q   <= 3'(LIVES);
            visible_q <= 1'b1;
            anim_q    <= '0;
            frame_q   <= '0;
            div_q     <= '0;
            inv_q     <= '0;
            blink_q   <= '0;
            jump_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            vy_q      <= vy_d;
            lives_q   <= lives_d;
            visible_q <= visible_d;
            anim_q    <= anim_d;
            frame_q   <= frame_d;
            div_q     <= div_d;
            inv_q     <= inv_d;
            blink_q   <= blink_d;
            jump_q    <= bus.jump;
            fall_q    <= bus.fall;
        end
    end

    assign bus.x               = 10'(X_POS);
    assign bus.y               = y_q;
    assign bus.vy              = vy_q;
    assign bus.state           = state_q;
    assign bus.animation_state = anim_q;
    assign bus.lives           = lives_q;
    assign bus.visible         = visible_q;

endmodule

// File: tb/tb_bird_motion.sv
// Scoreboard bench for bird_motion: the driver pushes the expected outputs for
// each tick it issues, the monitor pops and compares just after each edge.
module tb_bird_motion;

    localparam int NC = -999;  // field not checked

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bird_motion_if bus ();

    bird_motion dut (
        .clk_100Hz(clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    typedef struct {
        string name;
        int    y;
        int    vy;
        int    st;
        int    lv;
        int    vis;
        int    anim;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_out(input exp_t e);
        if (e.y != NC)    chk({e.name, " y"}, int'(bus.y), e.y);
        if (e.vy != NC)   chk({e.name, " vy"}, int'($signed(bus.vy)), e.vy);
        if (e.st != NC)   chk({e.name, " state"}, int'(bus.state), e.st);
        if (e.lv != NC)   chk({e.name, " lives"}, int'(bus.lives), e.lv);
        if (e.vis != NC)  chk({e.name, " visible"}, int'(bus.visible), e.vis);
        if (e.anim != NC) chk({e.name, " anim"}, int'(bus.animation_state), e.anim);
    endtask

    // Monitor: outputs are registered, so compare 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            cmp_out(e);
        end
    end

    task automatic tick(input logic s, input logic k, input logic j, input logic f,
                        input string nm, input int ey, input int evy, input int est,
                        input int elv, input int evis, input int eanim);
        exp_t e;
        @(negedge clk);
        bus.start = s;
        bus.kill  = k;
        bus.jump  = j;
        bus.fall  = f;
        e = '{name: nm, y: ey, vy: evy, st: est, lv: elv, vis: evis, anim: eanim};
        sb.push_back(e);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset(input string nm);
        exp_t e;
        e = '{name: nm, y: 200, vy: 0, st: 0, lv: 3, vis: 1, anim: 0};
        cmp_out(e);
        chk({nm, " x"}, int'(bus.x), 160);
    endtask

    initial begin
        int y;
        int vy;
        int k;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.jump  = 1'b0;
        bus.fall  = 1'b0;
        #12;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        tick(0, 0, 0, 0, "idle", 200, 0, 0, 3, 1, 0);
        tick(1, 0, 0, 0, "start", 200, 0, 1, 3, 1, 0);
        tick(0, 0, 0, 0, "grav1", 201, 1, 1, 3, 1, 0);
        tick(0, 0, 0, 0, "grav2", 203, 2, 1, 3, 1, 0);
        tick(0, 0, 0, 0, "grav3", 206, 3, 1, 3, 1, 0);

        // Jump held for 5 ticks fires once.
        tick(0, 0, 1, 0, "jump", 200, -6, 1, 3, 1, 0);
        tick(0, 0, 1, 0, "held1", 195, -5, 1, 3, 1, 0);
        tick(0, 0, 1, 0, "held2", 191, -4, 1, 3, 1, 0);
        tick(0, 0, 1, 0, "held3", 188, -3, 1, 3, 1, 0);
        tick(0, 0, 1, 0, "held4", 186, -2, 1, 3, 1, 0);

        // Free fall to the floor; frame advances every 8 ticks after the jump.
        y  = 186;
        vy = -2;
        k  = 4;
        for (int i = 0; i < 200; i++) begin
            vy = (vy + 1 > 10) ? 10 : vy + 1;
            y  = y + vy;
            k++;
            if (y >= 440) begin
                tick(0, 0, 0, 0, "floor hit", 440, 10, 2, 2, 1, (k / 8) % 3);
                break;
            end
            tick(0, 0, 0, 0, "fall", y, vy, 1, 3, 1, (k / 8) % 3);
        end

        // Invulnerability with blinking every 8 ticks.
        for (int t = 1; t <= 100; t++) begin
            if (t < 100) tick(0, 0, 0, 0, "hit", 440, 10, 2, 2, ((t / 8) % 2 == 0) ? 1 : 0, NC);
            else         tick(0, 0, 0, 0, "hit end", 440, 10, 1, 2, 1, NC);
        end

        // Floor contact and kill together lose only one life.
        tick(0, 1, 0, 0, "floor+kill", 440, 10, 2, 1, 1, NC);
        for (int t = 1; t <= 100; t++) begin
            if (t < 100) tick(0, 0, 0, 0, "hit2", NC, NC, NC, NC, NC, NC);
            else         tick(0, 0, 0, 0, "hit2 end", 440, 10, 1, 1, 1, NC);
        end

        tick(0, 0, 0, 0, "fatal", 440, 0, 3, 0, NC, 3);
        tick(0, 0, 1, 0, "dying floor", 440, 0, 4, 0, NC, 3);
        tick(0, 0, 0, 0, "dead hold", 440, 0, 4, 0, NC, 3);

        // Held start restarts only once.
        tick(1, 0, 0, 0, "restart", 200, 0, 1, 3, 1, 0);
        tick(1, 0, 0, 0, "start held", 201, 1, 1, 3, 1, 0);

        // 18 jump/release pairs, each -11: 201 -> 3.
        for (int p = 0; p < 18; p++) begin
            tick(0, 0, 1, 0, "pair jump", NC, NC, NC, NC, NC, NC);
            if (p < 17) tick(0, 0, 0, 0, "pair rel", NC, NC, NC, NC, NC, NC);
            else        tick(0, 0, 0, 0, "at y3", 3, -5, 1, 3, NC, NC);
        end
        tick(0, 0, 1, 0, "ceiling", 0, 0, 1, 3, NC, 0);
        tick(0, 0, 0, 0, "after ceiling", 1, 1, 1, 3, NC, NC);
        tick(0, 0, 0, 1, "fall edge", 11, 10, 1, 3, NC, NC);

        // Kill and jump in the same tick both apply.
        tick(0, 1, 1, 0, "kill+jump", 5, -6, 2, 2, 1, 0);
        tick(0, 0, 0, 0, "hit ceiling", 0, 0, 2, 2, NC, NC);

        // Asynchronous reset in the middle of HIT.
        drain();
        rst_n = 1'b0;
        #1;
        chk_reset("async reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, 0, 0, 0, "post reset", 200, 0, 0, 3, 1, 0);
        tick(0, 0, 0, 0, "post reset2", 200, 0, 0, 3, 1, 0);
        tick(1, 0, 0, 0, "start again", 200, 0, 1, 3, 1, 0);
        tick(0, 0, 0, 0, "idle end", 201, 1, 1, 3, 1, 0);
        drain();
        chk("scoreboard empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bird_motion.md
# bird_motion

Parametrised bird controller for the danmaku-bird game: it owns the bird's position, vertical velocity, life count and animation frame. It replaces the fixed single-life bird with configurable gravity, jump strength, play-field limits, lives with post-hit invulnerability, and a death-fall sequence. It is clocked by the 100 Hz game tick and feeds the sprite renderer and collision logic.

## Interface

- X_POS, 160: fixed bird x (10-bit).
- Y_INIT, 200: y after reset/restart (9-bit).
- Y_MIN, 0: ceiling.
- Y_MAX, 440: floor (top-left of sprite).
- GRAVITY, 1: velocity increment per tick.
- JUMP_VEL, 6: upward speed set by jump.
- VMAX, 10: terminal downward speed (≤ 63).
- LIVES, 3: lives per game (1..7).
- INVULN_TICKS, 100: invulnerability length after a non-fatal hit.
- ANIM_DIV, 8: ticks per wing frame.
- clk_100Hz  in  1  game tick clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start or restart pulse.
- kill  in  1  hit by a bullet.
- jump  in  1  flap request, rising-edge detected.
- fall  in  1  dive request, rising-edge detected.
- x  out  10  bird x, constant X_POS.
- y  out  9  bird y.
- vy  out  8  signed velocity, positive is downward.
- state  out  3  0 IDLE, 1 FLY, 2 HIT, 3 DYING, 4 DEAD.
- animation_state  out  2  wing frame 0..2; 3 means dead sprite.
- lives  out  3  remaining lives.
- visible  out  1  sprite enable; blinks during HIT.

## Operation

- Reset (async, rst_n=0): y=Y_INIT, vy=0, state=IDLE, animation_state=0, lives=LIVES, visible=1, edge registers cleared. x is always X_POS.
- jump and fall act only on 0→1 transitions, sampled against the previous cycle. A held level counts once.
- IDLE: y and vy are held. Frames cycle. start moves to FLY with vy=0.
- FLY and HIT motion are computed per tick in this priority order:
  - jump edge: vy'=-JUMP_VEL.
  - else fall edge: vy'=VMAX.
  - else: vy'=min(vy+GRAVITY, VMAX).
  - Then y'=y+vy', computed in signed 11-bit.
  - If y' ≤ Y_MIN: y=Y_MIN and vy=0.
  - If y' ≥ Y_MAX: y=Y_MAX.
- Floor contact (y' ≥ Y_MAX) in FLY counts as a kill.
- kill in FLY:
  - lives>1: lives-1, go to HIT, invulnerability counter=INVULN_TICKS.
  - lives==1: lives=0, go to DYING, vy=0.
- HIT: motion continues. kill and floor contact are ignored apart from the y clamp. visible toggles every 8 ticks. When the counter reaches 0, go to FLY with visible=1.
- DYING: jump and fall are ignored, gravity only, animation_state=3. Reaching Y_MAX moves to DEAD with vy=0.
- DEAD: everything is held, animation_state=3. start restarts the game: y=Y_INIT, vy=0, lives=LIVES, state=FLY, frame 0.
- start is ignored in FLY, HIT and DYING.
- Animation in IDLE, FLY and HIT: a divider counts ANIM_DIV ticks, then the frame goes 0→1→2→0. A jump edge restarts the divider and sets frame 0.

## Timing

- All outputs are registered. An input sampled at edge n is reflected in the outputs after edge n.
- A kill and a jump in the same tick: the kill state change applies and the jump also applies to vy (except in DYING).
- A kill and a floor contact in the same tick: one life is lost, not two.
- rst_n asserted mid-game returns all outputs to reset values immediately, with no clock needed.
- A start held high continuously after DEAD restarts only once. start is level-sampled but acts only in IDLE and DEAD.

## Test plan

- Reset, then a start pulse: state=1, y=200, vy=0. The next three ticks give y=201, 203, 206 and vy=1, 2, 3.
- FLY with vy=3 at y=206, jump pulse: vy=-6, y=200. Holding jump high for 5 ticks causes no further jumps, and vy climbs -5, -4, ….
- No input from y=200: vy saturates at 10. The bird reaches y=440, lives=2, state=2. After 100 ticks state=1 and visible=1.
- Third hit with lives=1: state=3, animation_state=3. Gravity-only fall to y=440 gives state=4. A start pulse then gives state=1, y=200, lives=3.
- Jump at y=3: y clamps to 0 and vy=0. A fall edge gives vy=10 on the next tick.
- rst_n pulled low during HIT: outputs go to the reset values asynchronously. After release, state=0 until start.
